// File: rtl/factor_row_pkg.sv
// factor_row_pkg: shared configuration, row type and channel state encoding for the
// factor-matrix row server.
//   row_t         one full rank row (RANK_FACTOR_MATRIX elements of FACTOR_MATRIX_WIDTH bits)
//   NM            number of request channels (one per input mode)
//   IDX_W, TAG_W  cache index / tag split of a row address
//   MW            width of the channel tag on the memory port
package factor_row_pkg;

    localparam int unsigned TENSOR_DIMENSIONS      = 3;
    localparam int unsigned RANK_FACTOR_MATRIX     = 16;
    localparam int unsigned FACTOR_MATRIX_WIDTH    = 32;
    localparam int unsigned MODE_TENSOR_ADDR_WIDTH = 16;
    localparam int unsigned CACHE_ROWS             = 64;

    localparam int unsigned NM     = TENSOR_DIMENSIONS - 1;
    localparam int unsigned ADDR_W = MODE_TENSOR_ADDR_WIDTH;
    localparam int unsigned IDX_W  = $clog2(CACHE_ROWS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W;
    localparam int unsigned MW     = (NM > 1) ? $clog2(NM) : 1;

    typedef logic [RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0] row_t;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StMissWait,
        StHold
    } chan_state_e;

endpackage

// File: rtl/factor_row_channel.sv
// factor_row_channel: one row-fetch channel with its direct-mapped row cache.
//   clk, rst      clock, synchronous active-low reset
//   flush_i       invalidate the whole cache; poisons an in-flight miss
//   req_en_i      one-cycle request, req_addr_i sampled with it
//   release_i     frees the held row
//   grant_i       this channel's miss request was accepted by memory
//   rsp_valid_i   memory response addressed to this channel, data in rsp_data_i
//   miss_req_o    channel waits for the arbiter; miss_addr_o is the row address
//   row_en_o      held row valid; row_data_o the row
module factor_row_channel
    import factor_row_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              req_en_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              release_i,
    input  logic              grant_i,
    input  logic              rsp_valid_i,
    input  row_t              rsp_data_i,
    output logic              miss_req_o,
    output logic [ADDR_W-1:0] miss_addr_o,
    output logic              row_en_o,
    output row_t              row_data_o
);

    chan_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              row_en_q;
    row_t              row_q;
    logic              poison_q;

    row_t              data_mem [CACHE_ROWS];
    logic [TAG_W-1:0]  tag_mem  [CACHE_ROWS];
    logic [CACHE_ROWS-1:0] valid_q, valid_d;

    row_t              rd_row_q;
    logic [TAG_W-1:0]  rd_tag_q;
    logic              rd_valid_q;

    logic              rd_en, fill, hit;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [TAG_W-1:0]  wr_tag;

    // A lookup starts from IDLE, or straight out of HOLD when release and a new request coincide.
    assign rd_en  = req_en_i && ((state_q == StIdle) || ((state_q == StHold) && release_i));
    assign rd_idx = req_addr_i[IDX_W-1:0];
    assign fill   = (state_q == StMissWait) && rsp_valid_i;
    assign wr_idx = addr_q[IDX_W-1:0];
    assign wr_tag = addr_q[ADDR_W-1:IDX_W];
    assign hit    = rd_valid_q && (rd_tag_q == wr_tag);

    // Flush beats a same-cycle fill; a poisoned fill never marks its entry valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (fill && !poison_q) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Row/tag storage: dual-port synchronous RAM, write-first on a shared index.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[wr_idx] <= rsp_data_i;
            tag_mem[wr_idx]  <= wr_tag;
        end
        if (rd_en) begin
            if (fill && (wr_idx == rd_idx)) begin
                rd_row_q <= rsp_data_i;
                rd_tag_q <= wr_tag;
            end else begin
                rd_row_q <= data_mem[rd_idx];
                rd_tag_q <= tag_mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            row_en_q   <= 1'b0;
            row_q      <= '0;
            poison_q   <= 1'b0;
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (rd_en) begin
                rd_valid_q <= valid_d[rd_idx];
            end
            unique case (state_q)
                StIdle: begin
                    if (req_en_i) begin
                        addr_q  <= req_addr_i;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    // A flush landing on the compare cycle invalidates the entry just read.
                    if (hit && !flush_i) begin
                        row_q    <= rd_row_q;
                        row_en_q <= 1'b1;
                        state_q  <= StHold;
                    end else begin
                        poison_q <= 1'b0;
                        state_q  <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (flush_i) poison_q <= 1'b1;
                    if (grant_i) state_q <= StMissWait;
                end
                StMissWait: begin
                    if (flush_i) poison_q <= 1'b1;
                    if (rsp_valid_i) begin
                        row_q    <= rsp_data_i;
                        row_en_q <= 1'b1;
                        state_q  <= StHold;
                    end
                end
                StHold: begin
                    if (release_i) begin
                        row_en_q <= 1'b0;
                        if (req_en_i) begin
                            addr_q  <= req_addr_i;
                            state_q <= StLookup;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miss_req_o  = (state_q == StMissReq);
    assign miss_addr_o = addr_q;
    assign row_en_o    = row_en_q;
    assign row_data_o  = row_q;

endmodule

// File: rtl/factor_row_server.sv
// factor_row_server: responder for the MTTKRP factor-matrix row fetch interface.
//   clk, rst                   clock, synchronous active-low reset
//   flush_i                    shard start: invalidate all channel caches
//   req_en_i / req_addr_i      per-channel request pulse and row address
//   release_i                  PE done: free all held rows
//   row_en_o / row_data_o      per-channel held row
//   mem_req_*                  shared, round-robin arbitrated miss request port
//   mem_rsp_*                  miss responses, tagged by channel, any order
module factor_row_server
    import factor_row_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [NM-1:0]          req_en_i,
    input  logic [NM-1:0][ADDR_W-1:0] req_addr_i,
    input  logic                   release_i,
    output logic [NM-1:0]          row_en_o,
    output row_t [NM-1:0]          row_data_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [MW-1:0]          mem_req_mode_o,
    output logic [ADDR_W-1:0]      mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [MW-1:0]          mem_rsp_mode_i,
    input  row_t                   mem_rsp_data_i
);

    logic [NM-1:0]             miss_req, grant, rsp_hit;
    logic [NM-1:0][ADDR_W-1:0] miss_addr;

    logic              req_valid_q, req_valid_d;
    logic [MW-1:0]     req_mode_q, req_mode_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [MW-1:0]     ptr_q, ptr_d;
    logic [MW-1:0]     cand;
    logic              found;

    for (genvar m = 0; m < NM; m++) begin : g_chan
        assign grant[m]   = req_valid_q && mem_req_ready_i && (req_mode_q == MW'(m));
        assign rsp_hit[m] = mem_rsp_valid_i && (mem_rsp_mode_i == MW'(m));

        factor_row_channel u_chan (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_i),
            .req_en_i    (req_en_i[m]),
            .req_addr_i  (req_addr_i[m]),
            .release_i   (release_i),
            .grant_i     (grant[m]),
            .rsp_valid_i (rsp_hit[m]),
            .rsp_data_i  (mem_rsp_data_i),
            .miss_req_o  (miss_req[m]),
            .miss_addr_o (miss_addr[m]),
            .row_en_o    (row_en_o[m]),
            .row_data_o  (row_data_o[m])
        );
    end

    // New arbitration only while the port is idle; the cycle after a handshake is a bubble,
    // so the just-granted channel (still in MISS_REQ that cycle) is never picked twice.
    always_comb begin
        req_valid_d = req_valid_q;
        req_mode_d  = req_mode_q;
        req_addr_d  = req_addr_q;
        ptr_d       = ptr_q;
        cand        = '0;
        found       = 1'b0;
        if (req_valid_q) begin
            if (mem_req_ready_i) begin
                req_valid_d = 1'b0;
                ptr_d       = MW'((32'(req_mode_q) + 32'd1) % NM);
            end
        end else begin
            for (int unsigned i = 0; i < NM; i++) begin
                cand = MW'((32'(ptr_q) + i) % NM);
                if (!found && miss_req[cand]) begin
                    found       = 1'b1;
                    req_valid_d = 1'b1;
                    req_mode_d  = cand;
                    req_addr_d  = miss_addr[cand];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_valid_q <= 1'b0;
            req_mode_q  <= '0;
            req_addr_q  <= '0;
            ptr_q       <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_mode_q  <= req_mode_d;
            req_addr_q  <= req_addr_d;
            ptr_q       <= ptr_d;
        end
    end

    assign mem_req_valid_o = req_valid_q;
    assign mem_req_mode_o  = req_mode_q;
    assign mem_req_addr_o  = req_addr_q;

endmodule

// File: tb/tb_factor_row_server.sv
// tb_factor_row_server: directed scenarios plus randomized serial fetches, checked against a
// per-channel direct-mapped cache model (index = addr % CACHE_ROWS, tag = addr / CACHE_ROWS).
module tb_factor_row_server;
    import factor_row_pkg::*;

    localparam int unsigned CW = $bits(row_t);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [NM-1:0]             req_en;
    logic [NM-1:0][ADDR_W-1:0] req_addr;
    logic                      rel;
    logic [NM-1:0]             row_en;
    row_t [NM-1:0]             row_data;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [MW-1:0]             mem_req_mode;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic                      rsp_valid;
    logic [MW-1:0]             rsp_mode;
    row_t                      rsp_data;

    factor_row_server dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .req_en_i        (req_en),
        .req_addr_i      (req_addr),
        .release_i       (rel),
        .row_en_o        (row_en),
        .row_data_o      (row_data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_mode_o  (mem_req_mode),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_mode_i  (rsp_mode),
        .mem_rsp_data_i  (rsp_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit               mc_valid [NM][CACHE_ROWS];
    logic [TAG_W-1:0] mc_tag   [NM][CACHE_ROWS];
    row_t             mc_row   [NM][CACHE_ROWS];
    row_t             exp_held [NM];

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_flush();
        foreach (mc_valid[i, j]) mc_valid[i][j] = 1'b0;
    endfunction

    function automatic bit model_hit(input int m, input logic [ADDR_W-1:0] a);
        int idx = int'(a) % CACHE_ROWS;
        return mc_valid[m][idx] && (mc_tag[m][idx] == TAG_W'(int'(a) / CACHE_ROWS));
    endfunction

    function automatic void model_fill(input int m, input logic [ADDR_W-1:0] a, input row_t r);
        int idx = int'(a) % CACHE_ROWS;
        mc_valid[m][idx] = 1'b1;
        mc_tag[m][idx]   = TAG_W'(int'(a) / CACHE_ROWS);
        mc_row[m][idx]   = r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < RANK_FACTOR_MATRIX; j++) r[j] = $urandom;
        return r;
    endfunction

    task automatic wait_req(output bit got);
        got = mem_req_valid;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            got = mem_req_valid;
        end
        check_eq("mem_req_timeout", got, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_row_en"}, row_en, 0);
        check_eq({tag, "_row_data0"}, row_data[0], 0);
        check_eq({tag, "_row_data1"}, row_data[1], 0);
        check_eq({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check_eq({tag, "_mem_req_mode"}, mem_req_mode, 0);
        check_eq({tag, "_mem_req_addr"}, mem_req_addr, 0);
    endtask

    // Fetch one row on channel m and leave it held.
    task automatic fetch(input int m, input logic [ADDR_W-1:0] a, input int stall, input int delay,
                         input bit flush_wait, input bit flush_rsp, input row_t data);
        int idx = int'(a) % CACHE_ROWS;
        bit exp_hit = model_hit(m, a);
        bit poison = 1'b0;
        bit got;
        req_en[m] = 1'b1;
        req_addr[m] = a;
        tick();
        req_en = '0;
        check_eq("lookup_row_en", row_en[m], 0);
        if (exp_hit) begin
            tick();
            check_eq("hit_row_en", row_en[m], 1);
            check_eq("hit_row_data", row_data[m], mc_row[m][idx]);
            check_eq("hit_no_mem_req", mem_req_valid, 0);
            exp_held[m] = mc_row[m][idx];
            return;
        end
        wait_req(got);
        if (!got) return;
        check_eq("miss_req_mode", mem_req_mode, m);
        check_eq("miss_req_addr", mem_req_addr, a);
        for (int c = 0; c < stall; c++) begin
            tick();
            check_eq("stall_valid", mem_req_valid, 1);
            check_eq("stall_mode", mem_req_mode, m);
            check_eq("stall_addr", mem_req_addr, a);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("req_drop_after_hs", mem_req_valid, 0);
        for (int c = 0; c < delay; c++) begin
            if (flush_wait && c == 0) begin
                flush = 1'b1;
                poison = 1'b1;
                model_flush();
            end
            tick();
            flush = 1'b0;
            check_eq("wait_row_en", row_en[m], 0);
        end
        rsp_valid = 1'b1;
        rsp_mode = MW'(m);
        rsp_data = data;
        if (flush_rsp) begin
            flush = 1'b1;
            model_flush();
        end
        tick();
        rsp_valid = 1'b0;
        flush = 1'b0;
        check_eq("fill_row_en", row_en[m], 1);
        check_eq("fill_row_data", row_data[m], data);
        exp_held[m] = data;
        if (!poison && !flush_rsp) model_fill(m, a, data);
    endtask

    // Optionally poke ignored events while holding, then release.
    task automatic hold_release(input int m, input bit stray);
        if (stray) begin
            rsp_valid = 1'b1;
            rsp_mode = MW'(m);
            rsp_data = rand_row();
            req_en[m] = 1'b1;
            req_addr[m] = ADDR_W'($urandom);
            tick();
            rsp_valid = 1'b0;
            req_en = '0;
            check_eq("stray_row_en", row_en[m], 1);
            check_eq("stray_row_data", row_data[m], exp_held[m]);
            check_eq("stray_no_mem_req", mem_req_valid, 0);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        check_eq("release_row_en", row_en[m], 0);
    endtask

    initial begin
        row_t ramp, ra, rb;
        bit got;
        rst = 1'b0;
        flush = 1'b0;
        req_en = '0;
        req_addr = '0;
        rel = 1'b0;
        mem_req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_mode = '0;
        rsp_data = '0;
        model_flush();
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Contention: both channels miss, port stalled, pointer at 0.
        ra = rand_row();
        rb = rand_row();
        req_en = 2'b11;
        req_addr[0] = 16'h0100;
        req_addr[1] = 16'h0201;
        tick();
        req_en = '0;
        wait_req(got);
        check_eq("cont_first_mode", mem_req_mode, 0);
        check_eq("cont_first_addr", mem_req_addr, 16'h0100);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("cont_stall_valid", mem_req_valid, 1);
            check_eq("cont_stall_mode", mem_req_mode, 0);
            check_eq("cont_stall_addr", mem_req_addr, 16'h0100);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        wait_req(got);
        check_eq("cont_second_mode", mem_req_mode, 1);
        check_eq("cont_second_addr", mem_req_addr, 16'h0201);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_mode = 1'b1;
        rsp_data = rb;
        tick();
        check_eq("ooo_first_row_en", row_en, 2'b10);
        rsp_mode = 1'b0;
        rsp_data = ra;
        tick();
        rsp_valid = 1'b0;
        check_eq("ooo_both_row_en", row_en, 2'b11);
        check_eq("ooo_row0", row_data[0], ra);
        check_eq("ooo_row1", row_data[1], rb);
        model_fill(0, 16'h0100, ra);
        model_fill(1, 16'h0201, rb);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        check_eq("ooo_release", row_en, 2'b00);

        // Cold miss with a ramp row, then a hit, then conflict eviction.
        for (int j = 0; j < RANK_FACTOR_MATRIX; j++) ramp[j] = FACTOR_MATRIX_WIDTH'(j + 1);
        fetch(0, 16'h0005, 0, 3, 1'b0, 1'b0, ramp);
        check_eq("cold_ramp_row", row_data[0], ramp);
        hold_release(0, 1'b1);
        fetch(0, 16'h0005, 0, 1, 1'b0, 1'b0, rand_row());
        hold_release(0, 1'b0);
        fetch(0, 16'h0045, 1, 1, 1'b0, 1'b0, rand_row());
        hold_release(0, 1'b0);
        fetch(0, 16'h0005, 0, 2, 1'b0, 1'b0, rand_row());
        hold_release(0, 1'b0);

        // Flush during MISS_WAIT: row delivered but not cached.
        fetch(0, 16'h0010, 0, 2, 1'b1, 1'b0, rand_row());
        hold_release(0, 1'b0);
        fetch(0, 16'h0010, 0, 1, 1'b0, 1'b0, rand_row());
        hold_release(0, 1'b0);

        // Back-to-back release + request on a cached row.
        fetch(0, 16'h0005, 0, 1, 1'b0, 1'b0, rand_row());
        rel = 1'b1;
        req_en[0] = 1'b1;
        req_addr[0] = 16'h0005;
        tick();
        rel = 1'b0;
        req_en = '0;
        check_eq("b2b_gap_row_en", row_en[0], 0);
        tick();
        check_eq("b2b_row_en", row_en[0], 1);
        check_eq("b2b_row_data", row_data[0], mc_row[0][5]);
        check_eq("b2b_no_mem_req", mem_req_valid, 0);
        hold_release(0, 1'b0);

        // Reset in the middle of a miss; the late response must be dropped.
        req_en[1] = 1'b1;
        req_addr[1] = 16'h0033;
        tick();
        req_en = '0;
        wait_req(got);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b1;
        model_flush();
        rsp_valid = 1'b1;
        rsp_mode = 1'b1;
        rsp_data = rand_row();
        tick();
        rsp_valid = 1'b0;
        check_eq("midrst_rsp_dropped", row_en, 0);
        tick();
        check_eq("midrst_no_req", mem_req_valid, 0);

        // Randomized serial fetches over a small address pool to force hits and conflicts.
        for (int n = 0; n < 150; n++) begin
            int m = int'($urandom_range(0, NM - 1));
            logic [ADDR_W-1:0] a;
            if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
            else a = ADDR_W'($urandom_range(0, 3) * CACHE_ROWS + $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                model_flush();
            end
            fetch(m, a, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rand_row());
            hold_release(m, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/factor_row_server.md
Name: factor_row_server

Overview:
- Responder side of the factor-matrix row fetch interface used by the MTTKRP processing element.
- One channel per input (non-output) mode. Each channel accepts a one-cycle address request, returns the full rank row and holds it until the PE releases it.
- Each channel has a small direct-mapped row cache. Misses go to external memory through a single shared, round-robin-arbitrated request port.

Parameters:
- TENSOR_DIMENSIONS, 3, tensor order; NM = TENSOR_DIMENSIONS-1 channels.
- RANK_FACTOR_MATRIX, 16, elements per row.
- FACTOR_MATRIX_WIDTH, 32, bits per element.
- MODE_TENSOR_ADDR_WIDTH, 16, row address width.
- CACHE_ROWS, 64, rows per channel cache; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  shard-start pulse; invalidates all caches.
- req_en  in  NM  per-mode request pulse.
- req_addr  in  NM x ADDR_W  per-mode row address; sampled only when req_en is high.
- release  in  1  PE op-done pulse; frees all held rows.
- row_en  out  NM  per-mode row valid (level).
- row_data  out  NM x RANK x FW  per-mode row.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts.
- mem_req_mode  out  MW  requesting channel, MW = max(1, clog2(NM)).
- mem_req_addr  out  ADDR_W  row address.
- mem_rsp_valid  in  1  response valid.
- mem_rsp_mode  in  MW  channel tag of the response.
- mem_rsp_data  in  RANK*FW  row data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All channels go to IDLE.
  - row_en=0, row_data=0, mem_req_valid=0, mem_req_mode=0, mem_req_addr=0.
  - All cache valid bits cleared; round-robin pointer set to 0.
  - Reset mid-miss abandons the miss; later responses are dropped.
- Channel FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, HOLD.
  - IDLE: on req_en[m], latch the address, issue a synchronous cache read at index addr[log2(CACHE_ROWS)-1:0], go to LOOKUP.
  - LOOKUP: compare the stored tag (upper address bits) and the valid bit.
    - Hit: load row_data and go to HOLD. For a request at cycle N, row_en rises at N+2.
    - Miss: go to MISS_REQ.
  - MISS_REQ: raise a request to the arbiter. When mem_req_valid && mem_req_ready with this channel granted, go to MISS_WAIT.
  - MISS_WAIT: on mem_rsp_valid with mem_rsp_mode==m:
    - load row_data, write the row and tag to the cache, set the valid bit;
    - go to HOLD; row_en rises the next cycle.
  - HOLD: row_en=1 with row_data stable until release.
    - On release go to IDLE; row_en=0 the next cycle.
    - If req_en[m] arrives in the same cycle as release, skip IDLE and go straight to LOOKUP with the new address.
- Ignored and dropped events:
  - req_en while not in IDLE (and not in the HOLD+release case) is ignored.
  - release outside HOLD is ignored.
  - mem_rsp_valid for a channel not in MISS_WAIT is dropped.
- Arbiter:
  - Round-robin over channels in MISS_REQ, starting at the pointer.
  - mem_req_valid, mode and addr are registered and held stable while mem_req_ready=0; the grant is not re-arbitrated mid-hold.
  - After a handshake the pointer moves to granted+1 mod NM.
  - At most one outstanding request per channel. Responses may return out of order across channels.
- Flush:
  - Clears all valid bits in one cycle.
  - A channel in MISS_REQ or MISS_WAIT marks its fill poisoned: the row is still delivered to the PE, but the valid bit is not set.
  - Flush and a fill write in the same cycle: flush wins, the entry stays invalid.
  - Flush does not disturb HOLD.
- Cache storage is a simple dual-port synchronous RAM per channel with write-first behaviour on the same index.

Decomposition:
- Package factor_row_pkg holds:
  - row_t (RANK x FW packed);
  - derived constants IDX_W = clog2(CACHE_ROWS), TAG_W = ADDR_W-IDX_W, MW;
  - channel state enum.
- Sub-module factor_row_channel: FSM, cache RAM, tag and valid arrays. Instantiated NM times.
- The arbiter stays in the top level.

Test Plan:
- Cold miss: req_en[0] with addr 0x0005; memory ready, response 3 cycles later with row r[j]=j+1 → mem_req_addr=0x0005, mode 0; row_en[0] rises the cycle after the response; row_data=r; held until release.
- Hit: repeat addr 0x0005 after release → no mem_req_valid; row_en[0] rises 2 cycles after req_en.
- Conflict eviction: addr 0x0045 (same index, CACHE_ROWS=64), then 0x0005 → both miss.
- Contention: req_en=2'b11 on cold addresses, pointer 0, mem_req_ready low for 4 cycles → request stays mode 0 stable; then mode 0 is granted, then mode 1. Respond to mode 1 first → row_en[1] rises before row_en[0].
- Flush during MISS_WAIT on addr 0x0010 → row still delivered; a later request for 0x0010 misses again.
- Back-to-back: in HOLD, release and req_en[0]=0x0005 (cached) in the same cycle → row_en[0] low for exactly 1 cycle, then high with the new row. Assert rst mid-MISS_WAIT → all outputs 0; a later response is ignored.
